// File: rtl/sb_rate_throttle.sv
// Token-bucket stream pacer: at most cfg_tokens transfers per cfg_window cycles.
// Define SB_RATE_THROTTLE_STATS_EN to compile in per-window transfer/stall statistics.
module sb_rate_throttle #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_en,
  input  logic [CW-1:0] cfg_window,
  input  logic [CW-1:0] cfg_tokens,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] stat_count,
  output logic [CW-1:0] stat_stalls,
  output logic          stat_valid
);

  typedef enum logic [1:0] {S_DIS, S_RUN, S_EXH} state_t;

  state_t        r_state;
  logic [CW-1:0] r_wcnt;
  logic [CW-1:0] r_tokens;
  logic [CW-1:0] r_win_len;

  logic          w_allow;
  logic          w_fire;
  logic          w_bound;
  logic [CW-1:0] w_last;

  // allow depends only on registered state: no in_valid -> in_ready path
  always_comb begin
    w_allow = 1'b0;
    case (r_state)
      S_DIS:   w_allow = 1'b1;
      S_RUN:   w_allow = (r_tokens != '0);
      default: w_allow = 1'b0;
    endcase
  end

  assign out_data  = in_data;
  assign out_valid = in_valid & w_allow;
  assign in_ready  = out_ready & w_allow;
  assign w_fire    = in_valid & out_ready & w_allow;

  // a window length of 0 behaves as 1
  assign w_last  = (r_win_len == '0) ? '0 : r_win_len - CW'(1);
  assign w_bound = (r_state != S_DIS) && (r_wcnt == w_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_DIS;
      r_wcnt    <= '0;
      r_tokens  <= '0;
      r_win_len <= '0;
    end else begin
      case (r_state)
        S_DIS: begin
          if (cfg_en) begin
            r_state   <= S_RUN;
            r_win_len <= cfg_window;
            r_tokens  <= cfg_tokens;
            r_wcnt    <= '0;
          end
        end
        default: begin
          if (!cfg_en) begin
            r_state  <= S_DIS;
            r_tokens <= '0;
            r_wcnt   <= '0;
          end else if (w_bound) begin
            // refill overwrites: leftover budget is dropped, a boundary transfer is not charged
            r_wcnt    <= '0;
            r_win_len <= cfg_window;
            r_tokens  <= cfg_tokens;
            r_state   <= (cfg_tokens != '0) ? S_RUN : S_EXH;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
            if (w_fire)
              r_tokens <= r_tokens - CW'(1);
            if (r_state == S_RUN && (r_tokens == '0 || (w_fire && r_tokens == CW'(1))))
              r_state <= S_EXH;
          end
        end
      endcase
    end
  end

`ifdef SB_RATE_THROTTLE_STATS_EN
  logic [CW-1:0] r_fcnt;
  logic [CW-1:0] r_scnt;
  logic [CW-1:0] r_stat_count;
  logic [CW-1:0] r_stat_stalls;
  logic          r_stat_valid;
  logic [CW-1:0] w_fcnt_nx;
  logic [CW-1:0] w_scnt_nx;
  logic          w_stall;

  assign w_stall   = in_valid & ~w_allow;
  assign w_fcnt_nx = (w_fire  && r_fcnt != '1) ? r_fcnt + CW'(1) : r_fcnt;
  assign w_scnt_nx = (w_stall && r_scnt != '1) ? r_scnt + CW'(1) : r_scnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fcnt        <= '0;
      r_scnt        <= '0;
      r_stat_count  <= '0;
      r_stat_stalls <= '0;
      r_stat_valid  <= 1'b0;
    end else begin
      r_stat_valid <= 1'b0;
      if (r_state == S_DIS || !cfg_en) begin
        r_fcnt <= '0;
        r_scnt <= '0;
      end else if (w_bound) begin
        r_stat_count  <= w_fcnt_nx;
        r_stat_stalls <= w_scnt_nx;
        r_stat_valid  <= 1'b1;
        r_fcnt        <= '0;
        r_scnt        <= '0;
      end else begin
        r_fcnt <= w_fcnt_nx;
        r_scnt <= w_scnt_nx;
      end
    end
  end

  assign stat_count  = r_stat_count;
  assign stat_stalls = r_stat_stalls;
  assign stat_valid  = r_stat_valid;
`else
  assign stat_count  = '0;
  assign stat_stalls = '0;
  assign stat_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_sb_rate_throttle.sv
// Scoreboard bench for sb_rate_throttle: expected transfer cycles and window stats are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_sb_rate_throttle;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_en;
  logic [CW-1:0] cfg_window;
  logic [CW-1:0] cfg_tokens;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] stat_count;
  logic [CW-1:0] stat_stalls;
  logic          stat_valid;

  sb_rate_throttle #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en),
    .cfg_window(cfg_window), .cfg_tokens(cfg_tokens),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .stat_count(stat_count), .stat_stalls(stat_stalls), .stat_valid(stat_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // payload tagged with the cycle it is offered in
  assign in_data = 32'hA500_0000 | 32'(cyc);

  typedef struct {
    int c;
    int cnt;
    int stl;
  } st_t;

  int  checks = 0;
  int  errors = 0;
  int  exp_q[$];
  st_t st_q[$];
  int  m_e;
  st_t m_s;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer: unexpected transfer at cycle %0d", cyc);
      end else begin
        m_e = exp_q.pop_front();
        if (m_e != cyc || out_data != (32'hA500_0000 | 32'(cyc))) begin
          errors++;
          $display("FAIL xfer: got cycle %0d data %0h, expected cycle %0d data %0h",
                   cyc, out_data, m_e, 32'hA500_0000 | 32'(m_e));
        end
      end
    end
`ifdef SB_RATE_THROTTLE_STATS_EN
    if (stat_valid) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL stat: unexpected stat_valid at cycle %0d", cyc);
      end else begin
        m_s = st_q.pop_front();
        if (m_s.c != cyc || int'(stat_count) != m_s.cnt || int'(stat_stalls) != m_s.stl) begin
          errors++;
          $display("FAIL stat: got cyc %0d count %0d stalls %0d, expected cyc %0d count %0d stalls %0d",
                   cyc, stat_count, stat_stalls, m_s.c, m_s.cnt, m_s.stl);
        end
      end
    end
`else
    checks++;
    if (stat_valid || stat_count != '0 || stat_stalls != '0) begin
      errors++;
      $display("FAIL stat_tied: got valid %0b count %0d stalls %0d, expected all 0",
               stat_valid, stat_count, stat_stalls);
    end
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_st(input int c, input int cnt, input int stl);
    st_t s;
    s.c = c; s.cnt = cnt; s.stl = stl;
    st_q.push_back(s);
  endtask

  int b;
  int c;

  initial begin
    reset = 1'b1; cfg_en = 1'b0; cfg_window = 16'd10; cfg_tokens = 16'd3;
    in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready_lo", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stat_count", 32'(stat_count), 32'd0);
    chk("rst_stat_stalls", 32'(stat_stalls), 32'd0);
    chk("rst_stat_valid", 32'(stat_valid), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready_hi", 32'(in_ready), 32'd1);
    step();
    reset = 1'b0;

    // transparent: every cycle transfers
    c = cyc;
    for (int i = 0; i < 100; i++) exp_q.push_back(c + i);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("transp_ready", 32'(in_ready), 32'(out_ready));
      step();
    end
    in_valid = 1'b0;

    // enable 3 per 10; window 0 starts the cycle after cfg_en is sampled
    cfg_en = 1'b1;
    step();
    b = cyc;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) exp_q.push_back(b + 10*k + j);
    exp_q.push_back(b + 38); exp_q.push_back(b + 39);
    for (int j = 0; j < 3; j++)  exp_q.push_back(b + 40 + j);
    for (int j = 0; j < 5; j++)  exp_q.push_back(b + 50 + j);
    for (int j = 0; j < 10; j++) exp_q.push_back(b + 70 + j);
    for (int j = 0; j < 3; j++)  exp_q.push_back(b + 81 + j);
    for (int j = 0; j < 4; j++)  exp_q.push_back(b + 86 + j);
    push_st(b + 10, 3, 7);
    push_st(b + 20, 3, 7);
    push_st(b + 30, 3, 7);
    push_st(b + 40, 2, 0);
    push_st(b + 50, 3, 7);
    push_st(b + 60, 5, 5);
    push_st(b + 70, 0, 10);
    for (int j = 0; j < 10; j++) push_st(b + 71 + j, 1, 0);
    push_st(b + 81, 0, 0);
    push_st(b + 97, 3, 7);

    goto(b + 30); out_ready = 1'b0;      // backpressure window cycles 0..7
    goto(b + 38); out_ready = 1'b1;
    goto(b + 41); cfg_tokens = 16'd5;    // mid-window change, applies next window
    goto(b + 55); cfg_tokens = 16'd0;    // fully blocked window
    goto(b + 65); cfg_window = 16'd0; cfg_tokens = 16'd1;
    goto(b + 80); in_valid = 1'b0; cfg_window = 16'd10; cfg_tokens = 16'd3;
    goto(b + 81); in_valid = 1'b1;
    goto(b + 85); reset = 1'b1;          // window cycle 4
    step();
    reset = 1'b0;
    chk("midrst_stat_valid", 32'(stat_valid), 32'd0);
    chk("midrst_stat_count", 32'(stat_count), 32'd0);
    chk("midrst_stat_stalls", 32'(stat_stalls), 32'd0);
    chk("midrst_transparent", 32'(out_valid), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'(out_ready));
    goto(b + 97); in_valid = 1'b0; cfg_en = 1'b0;
    goto(b + 100);

    chk("xfer_drain", 32'(exp_q.size()), 32'd0);
`ifdef SB_RATE_THROTTLE_STATS_EN
    chk("stat_drain", 32'(st_q.size()), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_rate_throttle.md
# sb_rate_throttle

Ready/valid stream pacer that enforces a programmed throughput: at most `cfg_tokens` transfers per `cfg_window` clock cycles. It is the enforcing counterpart to simulation-rate measurement: measurement reports how fast the design runs, and this block holds a switchboard stream to a chosen rate. It sits inline between a stream source and sink, typically at a switchboard queue boundary, to emulate slow links or to pace traffic in testbenches. It is synthesizable, with a zero-latency combinational data path and a sequential token-bucket controller.

## Interface

Parameters:
- `DW`, default 32: data width.
- `CW`, default 16: width of the window and token counters.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `cfg_en` input 1: 1 enables throttling; 0 makes the block transparent.
- `cfg_window` input CW: window length in cycles; 0 is treated as 1.
- `cfg_tokens` input CW: transfers allowed per window.
- `in_data` input DW, `in_valid` input 1, `in_ready` output 1: upstream stream.
- `out_data` output DW, `out_valid` output 1, `out_ready` input 1: downstream stream.
- `stat_count` output CW: transfers completed in the last finished window (stats build only).
- `stat_stalls` output CW: cycles in the last window where `in_valid` was blocked by the throttle (stats build only).
- `stat_valid` output 1: one-cycle pulse when the `stat_*` outputs update (stats build only).

## Operation

- Data path:
  - `out_data = in_data`.
  - `out_valid = in_valid & allow`.
  - `in_ready = out_ready & allow`.
  - `fire = in_valid & out_ready & allow`.
- `allow = 1` in state DISABLED; `allow = (tokens != 0)` in RUN; `allow = 0` in EXHAUSTED.
- Registers:
  - `wcnt` (CW): window cycle counter.
  - `tokens` (CW): remaining budget.
  - `win_len` and `win_tok`: latched copies of `cfg_window` and `cfg_tokens`.
- State machine:
  - DISABLED → RUN when `cfg_en = 1`. On this transition, latch `cfg_*`, set `tokens = cfg_tokens`, set `wcnt = 0`.
  - RUN → EXHAUSTED when `fire` occurs with `tokens == 1`, or when `tokens == 0`.
  - EXHAUSTED → RUN at a window boundary if the refill is nonzero.
  - RUN or EXHAUSTED → DISABLED when `cfg_en = 0`. This takes effect the next cycle; `tokens` and `wcnt` are cleared.
- Window boundary:
  - Occurs when `wcnt == max(win_len,1) - 1`. At the boundary, `wcnt` wraps to 0.
  - `cfg_*` is re-latched at each boundary, so configuration changes apply only at window edges.
  - `tokens` is overwritten with the newly latched `cfg_tokens`. Unused tokens are discarded, not accumulated.
- Simultaneous boundary and transfer: the transfer is gated by the old `tokens` value, and the refill overwrites it. The new window starts with its full budget.
- `tokens` never underflows. A decrement occurs only on `fire`, and `fire` requires `tokens != 0`.
- `cfg_tokens >= cfg_window` means the stream is never throttled, although the counters still run.
- `cfg_tokens == 0` with `cfg_en = 1` blocks the stream completely.

## Timing

- Data path latency is 0 cycles (combinational). `allow` is a pure function of registered state, so there is no combinational path from `in_valid` to `in_ready`.
- Reset values:
  - State DISABLED; `wcnt = 0`, `tokens = 0`.
  - `stat_count = 0`, `stat_stalls = 0`, `stat_valid = 0`.
  - Outputs follow the transparent path during and after reset until `cfg_en` is sampled high.
- Reset asserted mid-window returns the block to DISABLED on the next edge. Any in-flight budget is lost.
- After `cfg_en` rises, throttling begins on the following cycle.

## Configuration

- `SB_RATE_THROTTLE_STATS_EN` defined:
  - Per-window counters for `fire` and for blocked cycles (`in_valid & ~allow`) are compiled in.
  - At each window boundary they are copied to `stat_count` / `stat_stalls`, `stat_valid` pulses for 1 cycle, and the counters clear.
  - The boundary-cycle events are included in the closing window.
  - Both counters saturate at `2^CW - 1`.
- Undefined: the counters are removed, and `stat_count`, `stat_stalls` and `stat_valid` are tied to 0.

## Test plan

- Transparency: `cfg_en = 0`, continuous `in_valid`, `out_ready = 1` for 100 cycles → 100 transfers, data unchanged, `in_ready` always equals `out_ready`.
- Basic pacing: `cfg_window = 10`, `cfg_tokens = 3`, saturating source and sink → exactly 3 transfers in cycles 0–2 of each window, stalls on cycles 3–9. With stats: `stat_count = 3`, `stat_stalls = 7`, and `stat_valid` every 10 cycles.
- Backpressure: same configuration, `out_ready` low on window cycles 0–7 → transfers on cycles 8 and 9 only, `stat_count = 2`. No carry-over: the next window still allows 3.
- Reconfiguration: change `cfg_tokens` 3→5 mid-window → the current window is still limited to 3, and the next window allows 5.
- Edge values:
  - `cfg_window = 0`, `cfg_tokens = 1` → one transfer every cycle.
  - `cfg_tokens = 0` → zero transfers, with `stat_stalls` equal to the window length.
- Reset mid-window: assert `reset` for 1 cycle at window cycle 4 → all outputs at reset values, `stat_valid` low, and throttling resumes with a fresh window after `cfg_en` is sampled.
